ram_arbiter: RTL and testbench

Shares the instruction RAM and data RAM between the CPU pipeline and one external requester, such as the debug/program loader. The CPU keeps its direct RAM datapath whenever it is not preempted. The arbiter drives the RAM select lines, which use the encoding 00 = CPU path, 01 = external write, 10 = external read. It also runs a request/grant handshake with the external requester and stalls the CPU while the external requester owns a RAM.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram_arb_starve_cnt.sv | 27 ++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM states, RAM select encodings and the
// address-region decode that picks instruction RAM versus data RAM.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD      = 2'd2,
        S_RD_DATA = 2'd3
    } state_e;

    // Per-RAM select code: {rd_sel, wr_sel}
    localparam logic [1:0] SEL_CPU    = 2'b00;
    localparam logic [1:0] SEL_EXT_WR = 2'b01;
    localparam logic [1:0] SEL_EXT_RD = 2'b10;

    // Callers zero-extend to 64 bits so one decode serves any XLEN up to 64.
    function automatic logic in_dram(input logic [63:0] addr, input logic [63:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating wait counter for the external requester; flags starvation once
// the requester has waited MAX idle cycles. Used only under RAM_ARB_STARVE_EN.
module ram_arb_starve_cnt #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved = (cnt == W'(MAX));

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates instruction/data RAM between the CPU and one external requester.
// Optional starvation guard enabled by defining RAM_ARB_STARVE_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] DRAM_BASE  = 32'h0001_0000,
    parameter int              STARVE_MAX = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_iram_busy_i,
    input  logic            cpu_dram_busy_i,
    output logic            cpu_stall_o,
    input  logic            ext_req_i,
    input  logic            ext_we_i,
    input  logic [XLEN-1:0] ext_addr_i,
    input  logic [XLEN-1:0] ext_wdata_i,
    input  logic [3:0]      ext_byte_en_i,
    output logic            ext_gnt_o,
    output logic            ext_rvalid_o,
    output logic [XLEN-1:0] ext_rdata_o,
    input  logic [7:0]      iram_rdata_b_i,
    input  logic [7:0]      dram_rdata_b_i,
    input  logic [XLEN-1:0] dram_rdata_a_i,
    output logic            iram_rd_sel_o,
    output logic            iram_wr_sel_o,
    output logic            dram_rd_sel_o,
    output logic            dram_wr_sel_o,
    output logic [XLEN-1:0] ext_addr_o,
    output logic [XLEN-1:0] ext_wdata_o,
    output logic [3:0]      ext_byte_en_o,
    output logic            ext_wr_en_o
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    state_e     state, state_next;
    logic       req_dram, tgt_dram_q, tgt_busy, starved, grant, force_stall;
    logic [1:0] iram_sel, dram_sel;
    logic [XLEN-1:0] rdata_next;

    // Handshake: ext_req_i is held until ext_gnt_o pulses for one cycle; that
    // pulse consumes the request, and the access then completes unconditionally.
    assign req_dram    = in_dram(64'(ext_addr_i), 64'(DRAM_BASE));
    assign tgt_busy    = req_dram ? cpu_dram_busy_i : cpu_iram_busy_i;
    assign grant       = (state == S_IDLE) && ext_req_i && (!tgt_busy || starved);
    assign force_stall = (state == S_IDLE) && ext_req_i && starved;

`ifdef RAM_ARB_STARVE_EN
    ram_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     ((state == S_IDLE) && ext_req_i && !grant),
        .clr     (grant),
        .starved (starved)
    );
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            tgt_dram_q    <= 1'b0;
            ext_gnt_o     <= 1'b0;
            ext_rvalid_o  <= 1'b0;
            ext_rdata_o   <= '0;
            ext_addr_o    <= '0;
            ext_wdata_o   <= '0;
            ext_byte_en_o <= 4'b0000;
        end else begin
            state        <= state_next;
            ext_gnt_o    <= grant;
            ext_rvalid_o <= (state == S_RD_DATA);
            if (grant) begin
                tgt_dram_q    <= req_dram;
                ext_addr_o    <= ext_addr_i;
                ext_wdata_o   <= ext_wdata_i;
                ext_byte_en_o <= ext_byte_en_i;
            end
            if (state == S_RD_DATA) begin
                ext_rdata_o <= rdata_next;
            end
        end
    end

    // Full word only for an aligned data RAM read; everything else is one byte lane.
    always_comb begin
        rdata_next = {{(XLEN-8){1'b0}}, iram_rdata_b_i};
        if (tgt_dram_q) begin
            if (ext_addr_o[1:0] == 2'b00) begin
                rdata_next = dram_rdata_a_i;
            end else begin
                rdata_next = {{(XLEN-8){1'b0}}, dram_rdata_b_i};
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (grant) state_next = ext_we_i ? S_WR : S_RD;
            S_WR:      state_next = S_IDLE;
            S_RD:      state_next = S_RD_DATA;
            S_RD_DATA: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        iram_sel    = SEL_CPU;
        dram_sel    = SEL_CPU;
        ext_wr_en_o = 1'b0;
        case (state)
            S_WR: begin
                ext_wr_en_o = 1'b1;
                if (tgt_dram_q) dram_sel = SEL_EXT_WR;
                else            iram_sel = SEL_EXT_WR;
            end
            S_RD, S_RD_DATA: begin
                if (tgt_dram_q) dram_sel = SEL_EXT_RD;
                else            iram_sel = SEL_EXT_RD;
            end
            default: ;
        endcase
    end

    assign iram_rd_sel_o = iram_sel[1];
    assign iram_wr_sel_o = iram_sel[0];
    assign dram_rd_sel_o = dram_sel[1];
    assign dram_wr_sel_o = dram_sel[0];
    assign cpu_stall_o   = (state != S_IDLE) || force_stall;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with small byte-wide RAM models behind it.
// Covers the RAM_ARB_STARVE_EN build as well as the default build.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_iram_busy, cpu_dram_busy, cpu_stall;
    logic        ext_req, ext_we, ext_gnt, ext_rvalid, ext_wr_en;
    logic [31:0] ext_addr, ext_wdata, ext_rdata, ext_addr_q, ext_wdata_q;
    logic [3:0]  ext_be, ext_be_q;
    logic [7:0]  iram_rdata_b, dram_rdata_b;
    logic [31:0] dram_rdata_a;
    logic        iram_rd_sel, iram_wr_sel, dram_rd_sel, dram_wr_sel;

    logic [7:0]  iram_mem [256];
    logic [7:0]  dram_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cpu_iram_busy_i (cpu_iram_busy),
        .cpu_dram_busy_i (cpu_dram_busy),
        .cpu_stall_o     (cpu_stall),
        .ext_req_i       (ext_req),
        .ext_we_i        (ext_we),
        .ext_addr_i      (ext_addr),
        .ext_wdata_i     (ext_wdata),
        .ext_byte_en_i   (ext_be),
        .ext_gnt_o       (ext_gnt),
        .ext_rvalid_o    (ext_rvalid),
        .ext_rdata_o     (ext_rdata),
        .iram_rdata_b_i  (iram_rdata_b),
        .dram_rdata_b_i  (dram_rdata_b),
        .dram_rdata_a_i  (dram_rdata_a),
        .iram_rd_sel_o   (iram_rd_sel),
        .iram_wr_sel_o   (iram_wr_sel),
        .dram_rd_sel_o   (dram_rd_sel),
        .dram_wr_sel_o   (dram_wr_sel),
        .ext_addr_o      (ext_addr_q),
        .ext_wdata_o     (ext_wdata_q),
        .ext_byte_en_o   (ext_be_q),
        .ext_wr_en_o     (ext_wr_en)
    );

    // RAM models: asynchronous read at the registered address, byte-lane write.
    always_comb begin
        iram_rdata_b = iram_mem[ext_addr_q[7:0]];
        dram_rdata_b = dram_mem[ext_addr_q[7:0]];
        dram_rdata_a = {dram_mem[{ext_addr_q[7:2], 2'd3}], dram_mem[{ext_addr_q[7:2], 2'd2}],
                        dram_mem[{ext_addr_q[7:2], 2'd1}], dram_mem[{ext_addr_q[7:2], 2'd0}]};
    end

    always @(posedge clk) begin
        if (ext_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ext_be_q[i]) begin
                    if (iram_wr_sel) iram_mem[{ext_addr_q[7:2], 2'(i)}] <= ext_wdata_q[8*i +: 8];
                    if (dram_wr_sel) dram_mem[{ext_addr_q[7:2], 2'(i)}] <= ext_wdata_q[8*i +: 8];
                end
            end
        end
    end

    function automatic logic [31:0] sel_vec();
        return {28'd0, iram_rd_sel, iram_wr_sel, dram_rd_sel, dram_wr_sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds the current request for n cycles and expects it to stay ungranted.
    task automatic wait_no_grant(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_gnt"}, 32'(ext_gnt), 32'd0);
            check({tag, "_stall"}, 32'(cpu_stall), 32'd0);
            check({tag, "_sel"}, sel_vec(), 32'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input string tag);
        logic [31:0] exp_sel;
        exp_sel = (addr >= 32'h0001_0000) ? 32'h1 : 32'h4;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = addr; ext_wdata = wdata; ext_be = be;
        @(negedge clk);
        check({tag, "_gnt"}, 32'(ext_gnt), 32'd1);
        check({tag, "_sel"}, sel_vec(), exp_sel);
        check({tag, "_wren"}, 32'(ext_wr_en), 32'd1);
        check({tag, "_stall"}, 32'(cpu_stall), 32'd1);
        check({tag, "_addr"}, ext_addr_q, addr);
        check({tag, "_wdata"}, ext_wdata_q, wdata);
        check({tag, "_be"}, 32'(ext_be_q), 32'(be));
        ext_req = 1'b0;
        @(negedge clk);
        check({tag, "_gnt_end"}, 32'(ext_gnt), 32'd0);
        check({tag, "_sel_end"}, sel_vec(), 32'd0);
        check({tag, "_wren_end"}, 32'(ext_wr_en), 32'd0);
        check({tag, "_stall_end"}, 32'(cpu_stall), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
        logic [31:0] exp_sel;
        exp_sel = (addr >= 32'h0001_0000) ? 32'h2 : 32'h8;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = addr;
        @(negedge clk);
        check({tag, "_gnt"}, 32'(ext_gnt), 32'd1);
        check({tag, "_sel_rd"}, sel_vec(), exp_sel);
        check({tag, "_stall_rd"}, 32'(cpu_stall), 32'd1);
        check({tag, "_rvalid_rd"}, 32'(ext_rvalid), 32'd0);
        ext_req = 1'b0;
        @(negedge clk);
        check({tag, "_gnt_data"}, 32'(ext_gnt), 32'd0);
        check({tag, "_sel_data"}, sel_vec(), exp_sel);
        check({tag, "_stall_data"}, 32'(cpu_stall), 32'd1);
        check({tag, "_rvalid_data"}, 32'(ext_rvalid), 32'd0);
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(ext_rvalid), 32'd1);
        check({tag, "_rdata"}, ext_rdata, exp_data);
        check({tag, "_sel_end"}, sel_vec(), 32'd0);
        check({tag, "_stall_end"}, 32'(cpu_stall), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            iram_mem[i] = 8'h00;
            dram_mem[i] = 8'h00;
        end
        dram_mem[0] = 8'h44; dram_mem[1] = 8'h33; dram_mem[2] = 8'h22; dram_mem[3] = 8'h11;
        iram_mem[8'hFF] = 8'h5A;

        rst = 1'b1; cpu_iram_busy = 1'b0; cpu_dram_busy = 1'b0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", sel_vec(), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_gnt", 32'(ext_gnt), 32'd0);
        check("rst_rvalid", 32'(ext_rvalid), 32'd0);
        check("rst_wren", 32'(ext_wr_en), 32'd0);
        check("rst_addr", ext_addr_q, 32'd0);
        check("rst_wdata", ext_wdata_q, 32'd0);
        check("rst_rdata", ext_rdata, 32'd0);
        check("rst_be", 32'(ext_be_q), 32'd0);
        rst = 1'b0;

        // Instruction RAM word write, then byte readback lane by lane
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, "iwr");
        do_read(32'h0000_0010, 32'h0000_00EF, "ird0");
        do_read(32'h0000_0011, 32'h0000_00BE, "ird1");
        do_read(32'h0000_0012, 32'h0000_00AD, "ird2");
        do_read(32'h0000_0013, 32'h0000_00DE, "ird3");

        // Data RAM: unaligned byte read and aligned word read
        do_read(32'h0001_0003, 32'h0000_0011, "drd_byte");
        do_read(32'h0001_0000, 32'h1122_3344, "drd_word");

        // CPU owns the data RAM for 5 cycles
        cpu_dram_busy = 1'b1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0001_0000;
        wait_no_grant(5, "dbusy_wait");
        cpu_dram_busy = 1'b0;
        do_read(32'h0001_0000, 32'h1122_3344, "dbusy_rd");

        // Independent RAMs: the busy one does not block the other
        cpu_dram_busy = 1'b1;
        do_read(32'h0000_0011, 32'h0000_00BE, "indep_i");
        cpu_dram_busy = 1'b0;

        // Region boundary: DRAM_BASE-1 is instruction RAM, DRAM_BASE is data RAM
        cpu_iram_busy = 1'b1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0000_FFFF;
        wait_no_grant(3, "bound_wait");
        do_read(32'h0001_0000, 32'h1122_3344, "bound_d");
        cpu_iram_busy = 1'b0;
        do_read(32'h0000_FFFF, 32'h0000_005A, "bound_i");

        // Partial byte-enable write to the data RAM
        do_write(32'h0001_0004, 32'hAABB_CCDD, 4'b0101, "dwr_part");
        do_read(32'h0001_0004, 32'h00BB_00DD, "drd_part");

        // Request held high: one grant per IDLE/WR round trip
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0020; ext_wdata = 32'h0102_0304; ext_be = 4'hF;
        @(negedge clk);
        check("b2b_gnt0", 32'(ext_gnt), 32'd1);
        @(negedge clk);
        check("b2b_gnt1", 32'(ext_gnt), 32'd0);
        check("b2b_sel1", sel_vec(), 32'd0);
        @(negedge clk);
        check("b2b_gnt2", 32'(ext_gnt), 32'd1);
        check("b2b_sel2", sel_vec(), 32'h4);
        ext_req = 1'b0;
        @(negedge clk);
        check("b2b_gnt3", 32'(ext_gnt), 32'd0);
        do_read(32'h0000_0022, 32'h0000_0002, "b2b_rd");

        // Reset while in RD
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0000_0010;
        @(negedge clk);
        check("rstrd_gnt", 32'(ext_gnt), 32'd1);
        ext_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstrd_sel", sel_vec(), 32'd0);
        check("rstrd_rvalid", 32'(ext_rvalid), 32'd0);
        check("rstrd_stall", 32'(cpu_stall), 32'd0);
        check("rstrd_addr", ext_addr_q, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstrd_rvalid1", 32'(ext_rvalid), 32'd0);
        check("rstrd_sel1", sel_vec(), 32'd0);
        @(negedge clk);
        check("rstrd_rvalid2", 32'(ext_rvalid), 32'd0);
        check("rstrd_rdata", ext_rdata, 32'd0);

        // Persistent data RAM contention
        cpu_dram_busy = 1'b1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0001_0000;
`ifdef RAM_ARB_STARVE_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("starve_gnt", 32'(ext_gnt), 32'd0);
            check("starve_stall", 32'(cpu_stall), (i == 8) ? 32'd1 : 32'd0);
        end
        do_read(32'h0001_0000, 32'h1122_3344, "starve_rd");
        ext_req = 1'b1;
        wait_no_grant(1, "starve_clr");
        cpu_dram_busy = 1'b0;
        do_read(32'h0001_0000, 32'h1122_3344, "starve_rd2");
`else
        wait_no_grant(20, "strict_wait");
        cpu_dram_busy = 1'b0;
        do_read(32'h0001_0000, 32'h1122_3344, "strict_rd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
